reg_file_mp: RTL and testbench

Parametrised multi-read-port integer register file with a built-in busy scoreboard, replacing the fixed 2-read/1-write `RegFile` in the decode stage. It stores `NREGS` architectural registers of `XLEN` bits with register 0 hardwired to zero. It tracks which registers have an in-flight producer (busy bits set at issue, cleared at write-back) so decode can detect RAW hazards without a separate scoreboard. Optional same-cycle write-to-read bypass is compile-time selectable.

---
 rtl/reg_file_pkg.sv | 13 +
 rtl/reg_file_mp_busy_table.sv | 53 +++++
 rtl/reg_file_mp.sv | 84 ++++++++
 tb/tb_reg_file_mp.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the multi-port register file with busy scoreboard.
// Optional feature macro used by reg_file_mp: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
package reg_file_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NREAD_DEF = 2;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_idx_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/reg_file_mp_busy_table.sv
// Busy scoreboard: one bit per architectural register, set at issue, cleared at write-back or flush.
// Priority per register: Flush, then Issue, then write-back; bit 0 is never busy.
module busy_table
    import reg_file_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Issue,
    input  logic [AW-1:0]    IssueRd,
    input  logic             RegWrite,
    input  logic [AW-1:0]    rd,
    input  logic             Flush,
    output logic [NREGS-1:0] BusyMask
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Next busy vector with flush > issue > write-back priority
    always_comb begin
        w_busy_nxt = r_busy;
        if (Flush) begin
            w_busy_nxt = '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (i == 0) begin
                    w_busy_nxt[i] = 1'b0;
                end else if (Issue && (IssueRd == AW'(i))) begin
                    w_busy_nxt[i] = 1'b1;
                end else if (RegWrite && (rd == AW'(i))) begin
                    w_busy_nxt[i] = 1'b0;
                end else begin
                    w_busy_nxt[i] = r_busy[i];
                end
            end
        end
    end

    // Busy vector state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign BusyMask = r_busy;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised NREAD-port integer register file (x0 hardwired to zero) with built-in busy scoreboard.
// Define REGFILE_BYPASS_EN to forward the write-back value to matching read ports in the same cycle.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int NREAD = NREAD_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       RegWrite,
    input  logic [AW-1:0]              rd,
    input  logic [XLEN-1:0]            WriteData,
    input  logic [NREAD-1:0][AW-1:0]   rs,
    output logic [NREAD-1:0][XLEN-1:0] ReadData,
    output logic [NREAD-1:0]           ReadBusy,
    input  logic                       Issue,
    input  logic [AW-1:0]              IssueRd,
    input  logic                       Flush,
    output logic [NREGS-1:0]           BusyMask
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] w_busy;
    logic             w_wr_en;

    assign w_wr_en = RegWrite && (rd != '0);

    busy_table #(
        .NREGS (NREGS)
    ) u_busy_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .Issue    (Issue),
        .IssueRd  (IssueRd),
        .RegWrite (RegWrite),
        .rd       (rd),
        .Flush    (Flush),
        .BusyMask (w_busy)
    );

    assign BusyMask = w_busy;

    // Register storage; entry 0 is never written so it stays at its reset value of zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wr_en) begin
                r_regs[rd] <= WriteData;
            end
        end
    end

    // Independent combinational read ports with optional write-back forwarding
    always_comb begin
        ReadData = '0;
        ReadBusy = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (rs[p] == '0) begin
                ReadData[p] = '0;
                ReadBusy[p] = 1'b0;
            end else begin
`ifdef REGFILE_BYPASS_EN
                if (w_wr_en && (rd == rs[p])) begin
                    ReadData[p] = WriteData;
                    ReadBusy[p] = 1'b0;
                end else begin
                    ReadData[p] = r_regs[rs[p]];
                    ReadBusy[p] = w_busy[rs[p]];
                end
`else
                ReadData[p] = r_regs[rs[p]];
                ReadBusy[p] = w_busy[rs[p]];
`endif
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (default parameters, 2 read ports).
module tb_reg_file_mp;
    import reg_file_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic                 RegWrite;
    logic [4:0]           rd;
    logic [31:0]          WriteData;
    logic [1:0][4:0]      rs;
    logic [1:0][31:0]     ReadData;
    logic [1:0]           ReadBusy;
    logic                 Issue;
    logic [4:0]           IssueRd;
    logic                 Flush;
    logic [31:0]          BusyMask;

    int n_checks;
    int n_errors;

    reg_file_mp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWrite  (RegWrite),
        .rd        (rd),
        .WriteData (WriteData),
        .rs        (rs),
        .ReadData  (ReadData),
        .ReadBusy  (ReadBusy),
        .Issue     (Issue),
        .IssueRd   (IssueRd),
        .Flush     (Flush),
        .BusyMask  (BusyMask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, then drop all one-shot controls
    task automatic step();
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        Issue    = 1'b0;
        Flush    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; RegWrite = 1'b0; rd = 5'd0; WriteData = 32'd0;
        Issue = 1'b0; IssueRd = 5'd0; Flush = 1'b0;
        rs[0] = 5'd5; rs[1] = 5'd31;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ReadData !== 64'd0 || ReadBusy !== 2'b00 || BusyMask !== 32'd0) begin
            $display("FAIL reset_in: ReadData=%h ReadBusy=%b BusyMask=%h, want 0", ReadData, ReadBusy, BusyMask);
            n_errors++;
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (ReadData !== 64'd0 || ReadBusy !== 2'b00 || BusyMask !== 32'd0) begin
            $display("FAIL reset_after: ReadData=%h ReadBusy=%b BusyMask=%h, want 0", ReadData, ReadBusy, BusyMask);
            n_errors++;
        end
    endtask

    task automatic test_write_read();
        RegWrite = 1'b1; rd = 5'd5; WriteData = 32'd123;
        step();
        rs[0] = 5'd5; rs[1] = 5'd6;
        #1;
        n_checks++;
        if (ReadData[0] !== 32'd123 || ReadBusy[0] !== 1'b0) begin
            $display("FAIL write_read: data=%0d busy=%b, want 123/0", ReadData[0], ReadBusy[0]);
            n_errors++;
        end
        n_checks++;
        if (ReadData[1] !== 32'd0) begin
            $display("FAIL write_other: x6=%h, want 0", ReadData[1]);
            n_errors++;
        end
    endtask

    task automatic test_x0();
        RegWrite = 1'b1; rd = 5'd0; WriteData = 32'hDEADBEEF;
        step();
        rs[0] = 5'd0; rs[1] = 5'd0;
        #1;
        n_checks++;
        if (ReadData !== 64'd0 || ReadBusy !== 2'b00) begin
            $display("FAIL x0_write: ReadData=%h ReadBusy=%b, want 0", ReadData, ReadBusy);
            n_errors++;
        end
        Issue = 1'b1; IssueRd = 5'd0;
        step();
        n_checks++;
        if (BusyMask !== 32'd0) begin
            $display("FAIL x0_issue: BusyMask=%h, want 0", BusyMask);
            n_errors++;
        end
    endtask

    task automatic test_issue_writeback();
        Issue = 1'b1; IssueRd = 5'd7;
        step();
        rs[1] = 5'd7; rs[0] = 5'd7;
        #1;
        n_checks++;
        if (BusyMask !== 32'h0000_0080 || ReadBusy !== 2'b11) begin
            $display("FAIL issue_x7: BusyMask=%h ReadBusy=%b, want 00000080/11", BusyMask, ReadBusy);
            n_errors++;
        end
        RegWrite = 1'b1; rd = 5'd7; WriteData = 32'd42;
        step();
        n_checks++;
        if (BusyMask !== 32'd0 || ReadBusy[1] !== 1'b0 || ReadData[1] !== 32'd42) begin
            $display("FAIL wb_x7: BusyMask=%h busy=%b data=%0d, want 0/0/42", BusyMask, ReadBusy[1], ReadData[1]);
            n_errors++;
        end
    endtask

    task automatic test_issue_write_same();
        Issue = 1'b1; IssueRd = 5'd9;
        RegWrite = 1'b1; rd = 5'd9; WriteData = 32'd5;
        step();
        rs[0] = 5'd9; rs[1] = 5'd9;
        #1;
        n_checks++;
        if (ReadData[0] !== 32'd5 || ReadBusy !== 2'b11 || BusyMask !== 32'h0000_0200) begin
            $display("FAIL issue_wr_x9: data=%0d busy=%b mask=%h, want 5/11/00000200", ReadData[0], ReadBusy, BusyMask);
            n_errors++;
        end
    endtask

    task automatic test_flush();
        Issue = 1'b1; IssueRd = 5'd3;
        step();
        Issue = 1'b1; IssueRd = 5'd4;
        step();
        n_checks++;
        if (BusyMask !== 32'h0000_0218) begin
            $display("FAIL pre_flush: BusyMask=%h, want 00000218", BusyMask);
            n_errors++;
        end
        Flush = 1'b1; Issue = 1'b1; IssueRd = 5'd6;
        RegWrite = 1'b1; rd = 5'd11; WriteData = 32'd99;
        step();
        rs[0] = 5'd11; rs[1] = 5'd6;
        #1;
        n_checks++;
        if (BusyMask !== 32'd0 || ReadBusy !== 2'b00) begin
            $display("FAIL flush: BusyMask=%h ReadBusy=%b, want 0/00", BusyMask, ReadBusy);
            n_errors++;
        end
        n_checks++;
        if (ReadData[0] !== 32'd99) begin
            $display("FAIL flush_write: x11=%0d, want 99", ReadData[0]);
            n_errors++;
        end
    endtask

    task automatic test_reset_mid();
        RegWrite = 1'b1; rd = 5'd10; WriteData = 32'h0000_0010;
        step();
        Issue = 1'b1; IssueRd = 5'd8;
        RegWrite = 1'b1; rd = 5'd10; WriteData = 32'h0000_0055;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        rs[0] = 5'd10; rs[1] = 5'd5;
        #1;
        n_checks++;
        if (ReadData[0] !== 32'd0 || ReadData[1] !== 32'd0 || BusyMask !== 32'd0) begin
            $display("FAIL reset_mid: x10=%h x5=%h mask=%h, want 0/0/0", ReadData[0], ReadData[1], BusyMask);
            n_errors++;
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_now;
`ifdef REGFILE_BYPASS_EN
        exp_now = 32'd77;
`else
        exp_now = 32'd0;
`endif
        @(posedge clk);
        #1;
        rs[0] = 5'd12; rs[1] = 5'd12;
        RegWrite = 1'b1; rd = 5'd12; WriteData = 32'd77;
        #2;
        n_checks++;
        if (ReadData[0] !== exp_now || ReadData[1] !== exp_now) begin
            $display("FAIL bypass_same: p0=%0d p1=%0d, want %0d", ReadData[0], ReadData[1], exp_now);
            n_errors++;
        end
        step();
        n_checks++;
        if (ReadData[0] !== 32'd77 || ReadData[1] !== 32'd77) begin
            $display("FAIL bypass_next: p0=%0d p1=%0d, want 77", ReadData[0], ReadData[1]);
            n_errors++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_write_read();
        test_x0();
        test_issue_writeback();
        test_issue_write_same();
        test_flush();
        test_reset_mid();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
